// File: rtl/mem_access_sequencer_if.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer_if
//
// Purpose:
//   Bundles the request/ready handshake between the memory-access sequencer
//   and the variable-latency data memory.
//
// Signals:
//   mem_req    - request to memory (sequencer -> memory)
//   mem_we     - 1 = write, 0 = read (sequencer -> memory)
//   mem_addr   - latched access address (sequencer -> memory)
//   mem_wdata  - latched store data (sequencer -> memory)
//   mem_ready  - memory completes the current request (memory -> sequencer)
//   mem_rdata  - read data, valid with mem_ready (memory -> sequencer)
//
// Modports:
//   master - the sequencer side
//   slave  - the memory side
// -----------------------------------------------------------------------------
interface mem_access_sequencer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
//
// Purpose:
//   Turns the single-cycle wmem/rmem strobes from the control unit into a held
//   request/ready handshake with a variable-latency data memory. The pipeline
//   is stalled for the whole access, and an access that sees no mem_ready for
//   TIMEOUT consecutive request cycles is aborted with a one-cycle err pulse.
//
// Parameters:
//   AW      - address width
//   DW      - data width
//   TIMEOUT - request cycles without mem_ready before abort (1..255)
//
// Ports:
//   clk         - clock, all state on the rising edge
//   rst         - synchronous active-high reset
//   wmem, rmem  - write / read strobes from the control unit (write wins)
//   addr, wdata - access address and store data, latched on acceptance
//   mem         - memory handshake (master modport of mem_access_sequencer_if)
//   stall       - freeze upstream pipeline registers
//   rdata_out   - captured load data, held until the next read or timeout
//   rdata_valid - one-cycle pulse when a read completes
//   err         - one-cycle pulse when an access times out
// -----------------------------------------------------------------------------
module mem_access_sequencer #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wmem,
    input  logic                   rmem,
    input  logic [AW-1:0]          addr,
    input  logic [DW-1:0]          wdata,
    mem_access_sequencer_if.master mem,
    output logic                   stall,
    output logic [DW-1:0]          rdata_out,
    output logic                   rdata_valid,
    output logic                   err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    // The counter holds the number of REQ cycles already spent waiting. When
    // it equals TIMEOUT-1 during a non-ready REQ cycle, that cycle is the
    // TIMEOUT-th one, so the next state is ERR.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [DW-1:0] rdata_q, rdata_d;

    // The memory sees only the latched request, so the upstream address and
    // data are free to change while the access is in flight.
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = we_q;
    assign rdata_out     = rdata_q;

    // Next-state and output decode. Outputs are decoded from the state,
    // except that IDLE raises stall straight from the strobes so the
    // pipeline holds in the very cycle the access is accepted.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        stall       = 1'b0;
        mem.mem_req = 1'b0;
        rdata_valid = 1'b0;
        err         = 1'b0;

        case (state_q)
            IDLE: begin
                stall = wmem | rmem;
                if (wmem | rmem) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = wmem;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end

            REQ: begin
                stall       = 1'b1;
                mem.mem_req = 1'b1;
                // Completion is checked first so a ready on the last allowed
                // cycle still finishes normally.
                if (mem.mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // Clearing the load register on the way into ERR makes
                    // rdata_out read zero during the err pulse and after it.
                    if (cnt_q == CNT_LAST) begin
                        rdata_d = '0;
                        state_d = ERR;
                    end
                end
            end

            // Strobes seen here belong to the instruction just finished.
            DONE: begin
                rdata_valid = ~we_q;
                state_d     = IDLE;
            end

            ERR: begin
                err     = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_access_sequencer
//
// Self-checking bench for mem_access_sequencer. Each access is described by
// its strobes, the number of wait cycles k before mem_ready, and the expected
// outcome (length in cycles, write/read, timeout). The per-cycle expectations
// follow from the access timeline: cycle 0 accepts, cycles 1..len-2 request,
// the final cycle is DONE or ERR. Directed cases come from a table, further
// accesses are randomized, and reset corner cases are hand-written.
// -----------------------------------------------------------------------------
module tb_mem_access_sequencer;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wmem = 1'b0;
    logic          rmem = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          stall;
    logic [DW-1:0] rdata_out;
    logic          rdata_valid;
    logic          err;

    int            compared   = 0;
    int            mismatched = 0;
    logic [DW-1:0] rdata_model = '0;

    typedef struct {
        string         name;
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int            k;
        logic [DW-1:0] rdat;
        int            exp_len;
        logic          exp_we;
        logic          exp_err;
    } vec_t;

    vec_t vecs [5];

    mem_access_sequencer_if #(.AW(AW), .DW(DW)) mif ();

    mem_access_sequencer #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wmem(wmem),
        .rmem(rmem),
        .addr(addr),
        .wdata(wdata),
        .mem(mif),
        .stall(stall),
        .rdata_out(rdata_out),
        .rdata_valid(rdata_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later,
    // well away from the rising edge.
    task automatic applyStimulus(input logic wm, input logic rm,
                                 input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input logic rdy, input logic [DW-1:0] rdat,
                                 input logic r);
        @(negedge clk);
        wmem          = wm;
        rmem          = rm;
        addr          = a;
        wdata         = wd;
        mif.mem_ready = rdy;
        mif.mem_rdata = rdat;
        rst           = r;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Outputs expected whenever the sequencer sits idle with no strobes.
    task automatic checkIdle(input string tag);
        checkOutput({tag, " stall"},       DW'(stall),       '0);
        checkOutput({tag, " mem_req"},     DW'(mif.mem_req), '0);
        checkOutput({tag, " rdata_valid"}, DW'(rdata_valid), '0);
        checkOutput({tag, " err"},         DW'(err),         '0);
        checkOutput({tag, " rdata_out"},   rdata_out,        rdata_model);
    endtask

    // Idle cycles with random mem_ready / rdata noise, which must be ignored.
    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, AW'($urandom), DW'($urandom),
                          1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
            checkIdle(tag);
        end
    endtask

    // Drives one complete access and checks every cycle of it.
    task automatic runAccess(input vec_t v);
        for (int c = 0; c < v.exp_len; c++) begin
            logic          rdy;
            logic [DW-1:0] rdat;
            bit            last;
            bit            in_req;
            string         tag;
            last   = (c == v.exp_len - 1);
            in_req = (c >= 1) && (c <= v.exp_len - 2);
            tag    = $sformatf("%s c%0d", v.name, c);
            rdy    = 1'($urandom_range(0, 1));
            rdat   = DW'($urandom);
            if (in_req) begin
                rdy = (c == 1 + v.k);
                if (rdy) rdat = v.rdat;
            end
            if (c == 0) begin
                applyStimulus(v.wr, v.rd, v.a, v.wd, rdy, rdat, 1'b0);
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              AW'($urandom), DW'($urandom), rdy, rdat, 1'b0);
            end
            if (last) begin
                if (v.exp_err) rdata_model = '0;
                else if (!v.exp_we) rdata_model = v.rdat;
            end
            checkOutput({tag, " stall"}, DW'(stall), DW'(c < v.exp_len - 1));
            checkOutput({tag, " mem_req"}, DW'(mif.mem_req), DW'(in_req));
            checkOutput({tag, " rdata_valid"}, DW'(rdata_valid),
                        DW'(last && !v.exp_err && !v.exp_we));
            checkOutput({tag, " err"}, DW'(err), DW'(last && v.exp_err));
            checkOutput({tag, " rdata_out"}, rdata_out, rdata_model);
            if (in_req) begin
                checkOutput({tag, " mem_we"}, DW'(mif.mem_we), DW'(v.exp_we));
                checkOutput({tag, " mem_addr"}, DW'(mif.mem_addr), DW'(v.a));
                checkOutput({tag, " mem_wdata"}, mif.mem_wdata, v.wd);
            end
        end
    endtask

    initial begin
        vec_t rv;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;

        // Directed accesses; expected lengths are 3+k, or TIMEOUT+2 on abort.
        vecs[0] = '{"zero_wait_read", 1'b1, 1'b0, 32'h40, 32'h0, 0,
                    32'hDEADBEEF, 3, 1'b0, 1'b0};
        vecs[1] = '{"wait_write", 1'b0, 1'b1, 32'h10, 32'h1234, 3,
                    32'h0, 6, 1'b1, 1'b0};
        vecs[2] = '{"timeout_read", 1'b1, 1'b0, 32'h88, 32'h0, 99,
                    32'h0, 17, 1'b0, 1'b1};
        vecs[3] = '{"last_cycle_read", 1'b1, 1'b0, 32'hC4, 32'h0, 14,
                    32'hCAFEF00D, 17, 1'b0, 1'b0};
        vecs[4] = '{"both_strobes", 1'b1, 1'b1, 32'h20, 32'h5A5A, 1,
                    32'h0, 4, 1'b1, 1'b0};

        $display("[TB] reset and idle");
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        checkIdle("reset");
        checkOutput("reset mem_we",    DW'(mif.mem_we),   '0);
        checkOutput("reset mem_addr",  DW'(mif.mem_addr), '0);
        checkOutput("reset mem_wdata", mif.mem_wdata,     '0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        checkIdle("idle ready pulse");
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        checkIdle("idle after pulse");

        $display("[TB] directed table");
        for (int i = 0; i < 5; i++) begin
            runAccess(vecs[i]);
            if (i != 0) idleCycles(1, "table gap");
        end

        $display("[TB] reset mid-access");
        applyStimulus(1'b0, 1'b1, 32'h80, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        checkOutput("rst_mid c3 mem_req", DW'(mif.mem_req), DW'(1));
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'h1111_2222, 1'b0);
        rdata_model = '0;
        checkIdle("rst_mid c4");
        checkOutput("rst_mid c4 mem_addr", DW'(mif.mem_addr), '0);
        idleCycles(2, "rst_mid after");
        rv = '{"fresh_read", 1'b1, 1'b0, 32'h84, 32'h0, 2,
               32'h0BAD_F00D, 5, 1'b0, 1'b0};
        runAccess(rv);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 40; n++) begin
            int op;
            op       = int'($urandom_range(0, 2));
            rv.name  = $sformatf("rand%0d", n);
            rv.rd    = (op != 1);
            rv.wr    = (op != 0);
            rv.a     = AW'($urandom);
            rv.wd    = DW'($urandom);
            rv.rdat  = DW'($urandom);
            if ($urandom_range(0, 3) == 0)
                rv.k = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
            else
                rv.k = int'($urandom_range(0, 4));
            rv.exp_err = (rv.k >= TIMEOUT);
            rv.exp_len = rv.exp_err ? TIMEOUT + 2 : 3 + rv.k;
            rv.exp_we  = rv.wr;
            runAccess(rv);
            idleCycles(int'($urandom_range(0, 2)), "rand gap");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
